// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: writeback result source and memory-stage FSM states.
package riscv_pkg;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_t;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mux_3to1.sv
// Three-input select for the writeback result; select 11 falls back to input 0.
module mux_3to1 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      case (sel)
         2'b01:   y = d1;
         2'b10:   y = d2;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// RV32 memory stage: word load/store over a variable-latency req/ack bus, feeding the M/W register.
// Optional MEM_MISALIGN_CHECK_EN turns misaligned accesses into bus errors instead of word-aligning them.
module memory_stage
   import riscv_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        srst,
   input  logic [31:0] pc_plus4_m,
   input  logic [4:0]  rd_m,
   input  logic [31:0] alu_result_m,
   input  logic [31:0] write_data_m,
   input  logic [1:0]  result_src_m,
   input  logic        mem_write_m,
   input  logic        reg_write_m,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_m,
   output logic        reg_write_w,
   output logic [4:0]  rd_w,
   output logic [31:0] result_w,
   output logic        bus_err_w
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

   mem_state_t  state, state_nx;
   logic [7:0]  wait_cnt;

   logic [31:0] hold_addr, hold_wdata, hold_pc4;
   logic [4:0]  hold_rd;
   logic [1:0]  hold_src;
   logic        hold_we, hold_rw;

   logic        mem_op, misalign, capture;
   logic        wb_rw, wb_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_alu, wb_pc4, wb_result;
   logic [1:0]  wb_src;

   assign mem_op = mem_write_m | (result_src_m == RES_MEM);

`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = (alu_result_m[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      stall_m    = 1'b0;
      capture    = 1'b0;
      wb_rw      = 1'b0;
      wb_err     = 1'b0;
      wb_rd      = rd_m;
      wb_alu     = alu_result_m;
      wb_pc4     = pc_plus4_m;
      wb_src     = result_src_m;
      case (state)
         MEM_IDLE: begin
            if (mem_op && misalign) begin
               wb_err = 1'b1;
            end else if (mem_op) begin
               dmem_req   = 1'b1;
               dmem_we    = mem_write_m;
               dmem_addr  = {alu_result_m[31:2], 2'b00};
               dmem_wdata = write_data_m;
               if (dmem_ack) begin
                  wb_rw = reg_write_m;
               end else begin
                  stall_m  = 1'b1;
                  capture  = 1'b1;
                  state_nx = MEM_WAIT;
               end
            end else begin
               wb_rw = reg_write_m;
            end
         end
         MEM_WAIT: begin
            // Bus and writeback fields come from the hold registers; M inputs are ignored here.
            dmem_req   = 1'b1;
            dmem_we    = hold_we;
            dmem_addr  = {hold_addr[31:2], 2'b00};
            dmem_wdata = hold_wdata;
            wb_rd      = hold_rd;
            wb_alu     = hold_addr;
            wb_pc4     = hold_pc4;
            wb_src     = hold_src;
            if (dmem_ack) begin
               wb_rw    = hold_rw;
               state_nx = MEM_IDLE;
            end else begin
               stall_m = 1'b1;
               if (wait_cnt == TIMEOUT_CNT) begin
                  wb_err   = 1'b1;
                  state_nx = MEM_IDLE;
               end
            end
         end
         default: state_nx = MEM_IDLE;
      endcase
   end

   mux_3to1 #(.WIDTH(32)) u_result_mux (
      .sel (wb_src),
      .d0  (wb_alu),
      .d1  (dmem_rdata),
      .d2  (wb_pc4),
      .y   (wb_result)
   );

   always_ff @(posedge clk) begin
      if (srst) begin
         state       <= MEM_IDLE;
         wait_cnt    <= '0;
         hold_addr   <= '0;
         hold_wdata  <= '0;
         hold_pc4    <= '0;
         hold_rd     <= '0;
         hold_src    <= '0;
         hold_we     <= 1'b0;
         hold_rw     <= 1'b0;
         reg_write_w <= 1'b0;
         rd_w        <= '0;
         result_w    <= '0;
         bus_err_w   <= 1'b0;
      end else begin
         state <= state_nx;
         // Counter equals the number of WAIT cycles so far, so the first-req cycle plus
         // ACK_TIMEOUT wait cycles are stalled before the abort.
         if (capture) begin
            wait_cnt <= 8'd1;
         end else if (state == MEM_WAIT && state_nx == MEM_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end else begin
            wait_cnt <= '0;
         end
         if (capture) begin
            hold_addr  <= alu_result_m;
            hold_wdata <= write_data_m;
            hold_pc4   <= pc_plus4_m;
            hold_rd    <= rd_m;
            hold_src   <= result_src_m;
            hold_we    <= mem_write_m;
            hold_rw    <= reg_write_m;
         end
         reg_write_w <= wb_rw;
         bus_err_w   <= wb_err;
         rd_w        <= wb_rd;
         result_w    <= wb_result;
      end
   end

endmodule
